// File: rtl/program_counter_ras_if.sv
// rtl/program_counter_ras_if.sv - request/status bundle between frontend control and program_counter_ras
interface program_counter_ras_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic                  stall;
    logic                  jump_enable;
    logic                  call_enable;
    logic                  return_enable;
    logic [ADDR_WIDTH-1:0] target_address;
    logic [ADDR_WIDTH-1:0] counter_reg;
    logic [CW-1:0]         stack_count;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output stall, jump_enable, call_enable, return_enable, target_address,
        input  counter_reg, stack_count, stack_overflow, stack_underflow
    );

    modport slave (
        input  stall, jump_enable, call_enable, return_enable, target_address,
        output counter_reg, stack_count, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/program_counter_ras.sv
// rtl/program_counter_ras.sv - registered PC with return-address stack; PC_STACK_WRAP_EN selects circular RAS
module program_counter_ras #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic                  clk,
    input logic                  reset,
    program_counter_ras_if.slave bus
);
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_sp;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [PW-1:0]         w_sp_next;
    logic [PW-1:0]         w_sp_prev;
    logic                  w_full;
    logic                  w_empty;

    // r_sp is the next free slot; it wraps modulo STACK_DEPTH so that in the
    // circular build a push into a full stack lands on the oldest entry.
    always_comb begin
        w_pc_inc  = r_pc + 1'b1;
        w_sp_next = (r_sp == PW'(STACK_DEPTH - 1)) ? '0 : r_sp + 1'b1;
        w_sp_prev = (r_sp == '0) ? PW'(STACK_DEPTH - 1) : r_sp - 1'b1;
        w_full    = (r_count == CW'(STACK_DEPTH));
        w_empty   = (r_count == '0);
    end

    // One action per unstalled cycle: call > return > jump > increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc        <= RESET_VECTOR;
            r_count     <= '0;
            r_sp        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.call_enable) begin
                r_pc <= bus.target_address;
                if (!w_full) begin
                    r_stack[r_sp] <= w_pc_inc;
                    r_sp          <= w_sp_next;
                    r_count       <= r_count + 1'b1;
                end else begin
`ifdef PC_STACK_WRAP_EN
                    r_stack[r_sp] <= w_pc_inc;
                    r_sp          <= w_sp_next;
`else
                    r_overflow    <= 1'b1;
`endif
                end
            end else if (bus.return_enable) begin
                if (!w_empty) begin
                    r_pc    <= r_stack[w_sp_prev];
                    r_sp    <= w_sp_prev;
                    r_count <= r_count - 1'b1;
                end else begin
                    r_pc        <= w_pc_inc;
                    r_underflow <= 1'b1;
                end
            end else if (bus.jump_enable) begin
                r_pc <= bus.target_address;
            end else begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign bus.counter_reg     = r_pc;
    assign bus.stack_count     = r_count;
    assign bus.stack_overflow  = r_overflow;
    assign bus.stack_underflow = r_underflow;
endmodule

// File: tb/tb_program_counter_ras.sv
// tb/tb_program_counter_ras.sv - directed self-checking bench for program_counter_ras
module tb_program_counter_ras;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    program_counter_ras_if #(.ADDR_WIDTH(16), .STACK_DEPTH(4)) bus ();

    program_counter_ras #(
        .ADDR_WIDTH  (16),
        .STACK_DEPTH (4),
        .RESET_VECTOR(16'h0000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [15:0] pc, input int cnt,
                             input logic ovf, input logic unf);
        chk({tag, "_pc"},  32'(bus.counter_reg),     32'(pc));
        chk({tag, "_cnt"}, 32'(bus.stack_count),     32'(cnt));
        chk({tag, "_ovf"}, 32'(bus.stack_overflow),  32'(ovf));
        chk({tag, "_unf"}, 32'(bus.stack_underflow), 32'(unf));
    endtask

    task automatic idle();
        bus.stall          = 1'b0;
        bus.jump_enable    = 1'b0;
        bus.call_enable    = 1'b0;
        bus.return_enable  = 1'b0;
        bus.target_address = 16'h0000;
    endtask

    task automatic do_jump(input logic [15:0] t);
        idle();
        bus.jump_enable    = 1'b1;
        bus.target_address = t;
        step();
        idle();
    endtask

    task automatic do_call(input logic [15:0] t);
        idle();
        bus.call_enable    = 1'b1;
        bus.target_address = t;
        step();
        idle();
    endtask

    task automatic do_return();
        idle();
        bus.return_enable = 1'b1;
        step();
        idle();
    endtask

    logic [15:0] ret_exp [5];
    logic        ovf_exp;

    initial begin
        checks = 0;
        errors = 0;
        idle();
        reset = 1'b0;
        step();
        step();
        chk_state("reset", 16'h0000, 0, 1'b0, 1'b0);

        // sequential increment
        reset = 1'b1;
        step(); chk("inc1", 32'(bus.counter_reg), 32'h1);
        step(); chk("inc2", 32'(bus.counter_reg), 32'h2);
        step(); chk_state("inc3", 16'h0003, 0, 1'b0, 1'b0);

        // call from 0x3, run, return to 0x4
        do_call(16'h0040); chk_state("call", 16'h0040, 1, 1'b0, 1'b0);
        step();            chk("run1", 32'(bus.counter_reg), 32'h41);
        step();            chk("run2", 32'(bus.counter_reg), 32'h42);
        do_return();       chk_state("ret", 16'h0004, 0, 1'b0, 1'b0);

        // call beats return and jump in the same cycle
        do_jump(16'h0010); chk("jmp10", 32'(bus.counter_reg), 32'h10);
        bus.call_enable    = 1'b1;
        bus.return_enable  = 1'b1;
        bus.jump_enable    = 1'b1;
        bus.target_address = 16'h0100;
        step();
        idle();
        chk_state("prio", 16'h0100, 1, 1'b0, 1'b0);

        // stall with a pending jump holds everything
        bus.stall          = 1'b1;
        bus.jump_enable    = 1'b1;
        bus.target_address = 16'h0555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state("stall", 16'h0100, 1, 1'b0, 1'b0);
        end
        idle();
        do_return();       chk_state("ret_top", 16'h0011, 0, 1'b0, 1'b0);

        // empty-stack return increments and sets sticky underflow
        do_jump(16'h0020);
        do_return();       chk_state("underflow", 16'h0021, 0, 1'b0, 1'b1);

        // wrap from max address; underflow still sticky
        do_jump(16'hFFFF); chk("jmpffff", 32'(bus.counter_reg), 32'hFFFF);
        step();            chk_state("wrap", 16'h0000, 0, 1'b0, 1'b1);

        // five nested calls into a 4-deep stack
`ifdef PC_STACK_WRAP_EN
        ret_exp = '{16'h0051, 16'h0041, 16'h0031, 16'h0021, 16'h0022};
        ovf_exp = 1'b0;
`else
        ret_exp = '{16'h0041, 16'h0031, 16'h0021, 16'h0011, 16'h0012};
        ovf_exp = 1'b1;
`endif
        for (int i = 1; i <= 5; i++) begin
            do_jump(16'(i * 16));
            do_call(16'h0200);
        end
        chk_state("nest", 16'h0200, 4, ovf_exp, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_return();
            chk("nest_ret", 32'(bus.counter_reg), 32'(ret_exp[i]));
            chk("nest_cnt", 32'(bus.stack_count), 32'(i < 4 ? 3 - i : 0));
        end

        // reset wins over a simultaneous call at stack_count 2
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_state("reset2", 16'h0000, 0, 1'b0, 1'b0);
        do_call(16'h0300);
        do_call(16'h0300);
        chk("cnt2", 32'(bus.stack_count), 32'h2);
        bus.call_enable    = 1'b1;
        bus.target_address = 16'h0400;
        reset = 1'b0;
        step();
        idle();
        chk_state("rst_call", 16'h0000, 0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        chk_state("post_rst", 16'h0001, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_counter_ras.md
Name: program_counter_ras

Overview:
- Parametrised successor to the VR16 program counter: registered PC with sequential increment, absolute jump, call and return.
- Adds a hardware return-address stack (RAS) of configurable depth, a stall input and sticky stack-error flags.
- Sits in the frontend and drives the instruction_memory address directly. RAS replaces the single-entry return register.

Parameters:
- ADDR_WIDTH, 16: width of the PC, target and return addresses.
- STACK_DEPTH, 4: number of RAS entries. Legal range is 2 to 64.
- RESET_VECTOR, 0: PC value loaded on reset, ADDR_WIDTH bits wide.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- stall  input  1  high freezes all state; every request is ignored.
- jump_enable  input  1  load target_address into the PC.
- call_enable  input  1  push PC+1 onto the RAS, then load target_address.
- return_enable  input  1  pop the RAS top into the PC.
- target_address  input  ADDR_WIDTH  shared jump/call target.
- counter_reg  output  ADDR_WIDTH  current PC, registered.
- stack_count  output  $clog2(STACK_DEPTH+1)  number of valid RAS entries.
- stack_overflow  output  1  sticky; set by a push into a full stack.
- stack_underflow  output  1  sticky; set by a pop from an empty stack.

Behaviour:
- Reset (reset==0 at a clk edge): counter_reg=RESET_VECTOR, stack_count=0, stack_overflow=0, stack_underflow=0. RAS contents are don't-care. Reset overrides stall and all requests, including mid-call or mid-return.
- Stall: with stall==1, counter_reg, the RAS, stack_count and both flags hold their values.
- Priority when not stalled, one action per cycle: call_enable > return_enable > jump_enable > increment. Lower-priority requests in the same cycle are dropped, not queued.
- Increment: counter_reg <= counter_reg+1, modulo 2^ADDR_WIDTH. The maximum address wraps to 0.
- Jump: counter_reg <= target_address. RAS is untouched.
- Call:
  - push (counter_reg+1) mod 2^ADDR_WIDTH, then counter_reg <= target_address and stack_count+1.
  - A call at the maximum address pushes 0.
- Return, stack not empty: counter_reg <= top entry, stack_count-1.
- Return, stack empty: treated as an increment; stack_underflow <= 1; stack_count stays 0.
- Push when full: behaviour depends on the optional feature. The PC always loads target_address.
- Latency: every action takes effect at the next clk edge; counter_reg updates one cycle after the request is sampled. No combinational path from any input to any output.
- Flags are cleared only by reset. stack_count never exceeds STACK_DEPTH.
- RAS implementation: register array with a top-of-stack pointer; no memory macros.

Optional Feature:
- Macro: PC_STACK_WRAP_EN.
- Defined: the RAS is circular. A push when full overwrites the oldest entry, stack_count stays STACK_DEPTH, and stack_overflow is never set. The newest STACK_DEPTH return addresses remain retrievable in LIFO order.
- Undefined: a push when full is discarded. RAS contents and stack_count are unchanged, stack_overflow <= 1, and the PC still loads target_address.

Test Plan (defaults: ADDR_WIDTH=16, STACK_DEPTH=4, RESET_VECTOR=0):
- Reset then run 3 cycles -> counter_reg = 0, 1, 2, 3; stack_count=0; both flags 0.
- At PC=0x0003, call with target 0x0040; run 2 cycles; return -> PC 0x0040, 0x0041, 0x0042, then 0x0004; stack_count 1 then 0.
- Assert call, return and jump together (target 0x0100) at PC=0x0010 -> call wins: PC=0x0100, stack_count=1, top entry=0x0011. Then assert stall for 3 cycles with jump_enable=1 -> PC stays 0x0100.
- Return with an empty stack at PC=0x0020 -> PC=0x0021, stack_underflow=1 and remains 1 until reset. PC=0xFFFF with no request -> next PC=0x0000.
- Five nested calls from PCs 0x10, 0x20, 0x30, 0x40, 0x50 to 0x200, then five returns:
  - Without PC_STACK_WRAP_EN: stack_overflow=1; returns yield 0x41, 0x31, 0x21, 0x11, then underflow.
  - With PC_STACK_WRAP_EN: returns yield 0x51, 0x41, 0x31, 0x21, then underflow.
- Reset asserted in the same cycle as a call at stack_count=2 -> counter_reg=0, stack_count=0, flags 0; the call has no effect.
